// File: rtl/sequence_tx_if.sv
// rtl/sequence_tx_if.sv - request/serial-output bundle between a pattern source and sequence_tx
interface sequence_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             ready;
  logic             w;
  logic             w_valid;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output start, pattern, repeat_cnt,
    input  ready, w, w_valid, done, count
  );

  modport slave (
    input  start, pattern, repeat_cnt,
    output ready, w, w_valid, done, count
  );
endinterface

// File: rtl/sequence_tx.sv
// rtl/sequence_tx.sv - MSB-first serial frame transmitter with repeat count and inter-frame gap
// Outputs are decoded from state and registers only; inputs are sampled at start acceptance.
module sequence_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  sequence_tx_if.slave tx
);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_pat;
  logic [CNT_W-1:0] r_frames;
  logic [CNT_W-1:0] r_count;
  logic [BIT_W-1:0] r_bit;
  logic [GAP_W-1:0] r_gap;

  logic w_accept;
  logic w_last_bit;
  logic w_more;

  assign w_accept   = (r_state == S_IDLE) && tx.start;
  assign w_last_bit = (r_state == S_SHIFT) && (r_bit == '0);
  assign w_more     = (r_frames > CNT_W'(1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (tx.start) w_next = S_SHIFT;
      S_SHIFT: begin
        if (r_bit == '0) begin
          if (!w_more)       w_next = S_DONE;
          else if (GAP == 0) w_next = S_SHIFT;
          else               w_next = S_GAP;
        end
      end
      S_GAP:   if (r_gap == '0) w_next = S_SHIFT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Later frames reload from r_pat so a changing tx.pattern cannot corrupt them.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_shreg  <= '0;
      r_pat    <= '0;
      r_frames <= '0;
      r_count  <= '0;
      r_bit    <= '0;
      r_gap    <= '0;
    end else if (w_accept) begin
      r_shreg  <= tx.pattern;
      r_pat    <= tx.pattern;
      r_frames <= (tx.repeat_cnt == '0) ? CNT_W'(1) : tx.repeat_cnt;
      r_count  <= '0;
      r_bit    <= BIT_LOAD;
    end else if (w_last_bit) begin
      r_count  <= r_count + 1'b1;
      r_frames <= r_frames - 1'b1;
      r_shreg  <= r_pat;
      r_bit    <= BIT_LOAD;
      r_gap    <= GAP_LOAD;
    end else if (r_state == S_SHIFT) begin
      r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
      r_bit    <= r_bit - 1'b1;
    end else if ((r_state == S_GAP) && (r_gap != '0)) begin
      r_gap    <= r_gap - 1'b1;
    end
  end

  always_comb begin
    tx.ready   = 1'b0;
    tx.w       = 1'b0;
    tx.w_valid = 1'b0;
    tx.done    = 1'b0;
    case (r_state)
      S_IDLE:  tx.ready = 1'b1;
      S_SHIFT: begin
        tx.w       = r_shreg[WIDTH-1];
        tx.w_valid = 1'b1;
      end
      S_DONE:  tx.done = 1'b1;
      default: ;
    endcase
  end

  assign tx.count = r_count;
endmodule

// File: tb/tb_sequence_tx.sv
// tb/tb_sequence_tx.sv - directed bench for sequence_tx with a 1101 Moore detector on the link
module tb_sequence_tx;
  logic Clock = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clock = ~Clock;

  sequence_tx_if #(.WIDTH(4), .CNT_W(4)) if_g1 ();
  sequence_tx_if #(.WIDTH(4), .CNT_W(4)) if_g0 ();

  sequence_tx #(.WIDTH(4), .GAP(1), .CNT_W(4)) dut_g1 (.Clock(Clock), .Reset(Reset), .tx(if_g1));
  sequence_tx #(.WIDTH(4), .GAP(0), .CNT_W(4)) dut_g0 (.Clock(Clock), .Reset(Reset), .tx(if_g0));

  // Detector for 1101 that returns to its default state unconditionally after a hit.
  logic [2:0] det_g1, det_g0;
  logic       z_g1, z_g0;

  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd2 : 3'd0;
      3'd2:    return b ? 3'd2 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      det_g1 <= 3'd0;
      det_g0 <= 3'd0;
    end else begin
      det_g1 <= det_next(det_g1, if_g1.w);
      det_g0 <= det_next(det_g0, if_g0.w);
    end
  end

  assign z_g1 = (det_g1 == 3'd4);
  assign z_g0 = (det_g0 == 3'd4);

  task automatic test_reset;
    logic [3:0] got1, got0;
    got1 = {if_g1.ready, if_g1.w, if_g1.w_valid, if_g1.done};
    got0 = {if_g0.ready, if_g0.w, if_g0.w_valid, if_g0.done};
    n_cmp++;
    if (got1 !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_g1 {ready,w,w_valid,done}: got %b want 1000", got1);
    end
    n_cmp++;
    if (got0 !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_g0 {ready,w,w_valid,done}: got %b want 1000", got0);
    end
    n_cmp++;
    if (if_g1.count !== 4'd0 || if_g0.count !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d/%0d want 0/0", if_g1.count, if_g0.count);
    end
  endtask

  // Single frame 1101 on the GAP=1 instance; caller sits just after a rising edge with the DUT idle.
  task automatic test_basic(input logic [3:0] rpt, input string tag);
    logic [31:0] ew = 32'h16, ev = 32'h1E, ed = 32'h20, er = 32'h40, ez = 32'h20;
    logic [4:0] got, exp;
    if_g1.pattern = 4'b1101;
    if_g1.repeat_cnt = rpt;
    if_g1.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge Clock); #1;
      if (c == 1) if_g1.start = 1'b0;
      got = {if_g1.w, if_g1.w_valid, if_g1.done, if_g1.ready, z_g1};
      exp = {ew[c], ev[c], ed[c], er[c], ez[c]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s cycle %0d {w,w_valid,done,ready,z}: got %b want %b", tag, c, got, exp);
      end
    end
    n_cmp++;
    if (if_g1.count !== 4'd1) begin
      n_bad++;
      $display("FAIL %s count: got %0d want 1", tag, if_g1.count);
    end
  endtask

  task automatic test_multi_frame;
    logic [31:0] ew = 32'h5AD6, ev = 32'h7BDE, ed = 32'h8000, er = 32'h10000, ez = 32'h8420;
    logic [4:0] got, exp;
    if_g1.pattern = 4'b1101;
    if_g1.repeat_cnt = 4'd3;
    if_g1.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge Clock); #1;
      if (c == 1) if_g1.start = 1'b0;
      got = {if_g1.w, if_g1.w_valid, if_g1.done, if_g1.ready, z_g1};
      exp = {ew[c], ev[c], ed[c], er[c], ez[c]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL multi cycle %0d {w,w_valid,done,ready,z}: got %b want %b", c, got, exp);
      end
      if (c == 5 || c == 10 || c == 16) begin
        n_cmp++;
        if (if_g1.count !== ((c == 5) ? 4'd1 : (c == 10) ? 4'd2 : 4'd3)) begin
          n_bad++;
          $display("FAIL multi count cycle %0d: got %0d", c, if_g1.count);
        end
      end
    end
  endtask

  task automatic test_gap0;
    logic [31:0] ew = 32'h176, ev = 32'h1FE, ed = 32'h200, er = 32'h400, ez = 32'h20;
    logic [4:0] got, exp;
    if_g0.pattern = 4'b1101;
    if_g0.repeat_cnt = 4'd2;
    if_g0.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clock); #1;
      if (c == 1) if_g0.start = 1'b0;
      got = {if_g0.w, if_g0.w_valid, if_g0.done, if_g0.ready, z_g0};
      exp = {ew[c], ev[c], ed[c], er[c], ez[c]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL gap0 cycle %0d {w,w_valid,done,ready,z}: got %b want %b", c, got, exp);
      end
    end
    n_cmp++;
    if (if_g0.count !== 4'd2) begin
      n_bad++;
      $display("FAIL gap0 count: got %0d want 2", if_g0.count);
    end
  endtask

  task automatic test_busy_ignored;
    logic [31:0] ew = 32'h16, ev = 32'h1E, ed = 32'h20, er = 32'h1C0;
    logic [3:0] got, exp;
    if_g1.pattern = 4'b1101;
    if_g1.repeat_cnt = 4'd1;
    if_g1.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge Clock); #1;
      if (c == 1) if_g1.start = 1'b0;
      got = {if_g1.w, if_g1.w_valid, if_g1.done, if_g1.ready};
      exp = {ew[c], ev[c], ed[c], er[c]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL busy cycle %0d {w,w_valid,done,ready}: got %b want %b", c, got, exp);
      end
      if (c == 2) begin
        if_g1.start = 1'b1;
        if_g1.pattern = 4'b0000;
        if_g1.repeat_cnt = 4'd5;
      end
      if (c == 3) if_g1.start = 1'b0;
    end
    n_cmp++;
    if (if_g1.count !== 4'd1) begin
      n_bad++;
      $display("FAIL busy count: got %0d want 1", if_g1.count);
    end
  endtask

  task automatic test_start_held;
    logic [31:0] ew = 32'h196, ev = 32'h19E, ed = 32'h20, er = 32'h40;
    logic [3:0] got, exp;
    logic       seen;
    if_g1.pattern = 4'b1101;
    if_g1.repeat_cnt = 4'd1;
    if_g1.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge Clock); #1;
      got = {if_g1.w, if_g1.w_valid, if_g1.done, if_g1.ready};
      exp = {ew[c], ev[c], ed[c], er[c]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL held cycle %0d {w,w_valid,done,ready}: got %b want %b", c, got, exp);
      end
    end
    if_g1.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge Clock); #1;
      seen = if_g1.ready;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++;
      $display("FAIL held_drain ready: got %b want 1 within 20 cycles", seen);
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] got;
    if_g1.pattern = 4'b1101;
    if_g1.repeat_cnt = 4'd1;
    if_g1.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clock); #1;
      if (c == 1) if_g1.start = 1'b0;
    end
    n_cmp++;
    if (if_g1.w_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid pre w_valid: got %b want 1", if_g1.w_valid);
    end
    #1 Reset = 1'b1;
    #1;
    got = {if_g1.ready, if_g1.w, if_g1.w_valid, if_g1.done, |if_g1.count};
    n_cmp++;
    if (got !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_mid async {ready,w,w_valid,done,count!=0}: got %b want 10000", got);
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clock); #1;
      got = {if_g1.ready, if_g1.w, if_g1.w_valid, if_g1.done, 1'b0};
      n_cmp++;
      if (got !== 5'b10000) begin
        n_bad++;
        $display("FAIL reset_mid after %0d {ready,w,w_valid,done,0}: got %b want 10000", c, got);
      end
    end
    test_basic(4'd1, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    if_g1.start = 1'b0; if_g1.pattern = 4'b0000; if_g1.repeat_cnt = 4'd0;
    if_g0.start = 1'b0; if_g0.pattern = 4'b0000; if_g0.repeat_cnt = 4'd0;
    #12;
    test_reset;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    test_basic(4'd1, "basic");
    test_multi_frame;
    test_gap0;
    test_busy_ignored;
    test_start_held;
    test_reset_mid;
    test_basic(4'd0, "repeat0");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sequence_tx.md
Name: sequence_tx

Overview:
Serial pattern transmitter that drives the single-bit `w` input of the team's Moore sequence detector. On a start request it captures a WIDTH-bit pattern and shifts it out MSB-first, one bit per clock. It repeats the frame a programmable number of times, with a programmable idle gap of zeros between frames. It reports completion with a one-cycle done pulse and serves as the stimulus/transmit end of the detector link.

Parameters:
- WIDTH, 4, bits per frame (≥2).
- GAP, 1, idle cycles (w=0) inserted between consecutive frames (≥0).
- CNT_W, 4, width of repeat and count fields.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  transmit request; accepted only at a rising edge where ready=1.
- pattern  in  WIDTH  frame bits; captured at start acceptance.
- repeat  in  CNT_W  number of frames to send; 0 is treated as 1; captured at acceptance.
- ready  out  1  high only in IDLE.
- w  out  1  serial data to the detector; 0 whenever w_valid=0.
- w_valid  out  1  high while a frame bit is on w.
- done  out  1  one-cycle pulse after the last bit of the last frame.
- count  out  CNT_W  frames fully sent since the last accepted start.

Behaviour:
- Clock and reset: clock Clock; reset Reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, w=0, w_valid=0, done=0, count=0, shift register=0, frame and gap counters=0.
- Output style: all outputs are registered Moore outputs decoded from state and registers, with no combinational path from inputs.
- Cycle convention: cycle n is the interval after rising edge n.
- IDLE:
  - ready=1, w=0.
  - If start=1 at an edge, latch pattern into the shift register, latch repeat (0→1) into the frame counter, clear count, and go to SHIFT.
- SHIFT:
  - w=shreg[WIDTH-1], w_valid=1.
  - Shift left by one each edge; the bit counter runs WIDTH-1..0.
  - Exactly WIDTH cycles per frame.
  - On the edge ending the last bit: count+1 and frame counter-1.
  - If frames remain: reload the shift register from the latched pattern (not the live input), then go to GAP (or directly to SHIFT if GAP=0).
  - Otherwise go to DONE.
- GAP: w=0, w_valid=0 for exactly GAP cycles, then SHIFT.
- DONE: done=1 and w=0 for exactly one cycle, then IDLE.
- Latency: start accepted at edge 0 → first bit in cycle 1.
- Single-frame total: WIDTH bit cycles + 1 done cycle; ready returns in cycle WIDTH+2.
- Multi-frame timing: frame k (k=0..R-1) occupies cycles 1+k*(WIDTH+GAP) .. k*(WIDTH+GAP)+WIDTH. There is no gap after the final frame. done is high in cycle R*WIDTH+(R-1)*GAP+1.
- Boundary conditions:
  - start while busy: ignored, no effect on the current transmission.
  - pattern or repeat changing mid-transmission: no effect.
  - start held high continuously: one transmission per IDLE visit.
  - Reset asserted mid-frame: immediately returns to reset values; the partial frame is abandoned with no done pulse.
  - count: never wraps, since max repeat is 2^CNT_W-1.
- Detector compatibility: the detector returns to its default state unconditionally after a detection, so GAP≥1 is required for back-to-back frames to be detected. GAP=0 is legal, but frames after the first are then not detected.

Test Plan:
1. Basic frame: WIDTH=4, pattern=4'b1101, repeat=1, start pulsed at edge 0 → w=1,1,0,1 with w_valid=1 in cycles 1–4; done=1 in cycle 5 only; ready=1 from cycle 6; count=1.
2. Loopback with the detector, repeat=3, GAP=1 → frames in cycles 1–4, 6–9, 11–14; w=0 in cycles 5 and 10; detector z=1 in cycles 5, 10, 15; done in cycle 15; count=3.
3. GAP=0, repeat=2, pattern 1101 → w=1,1,0,1,1,1,0,1 in cycles 1–8; done in cycle 9; detector z=1 only in cycle 5.
4. Ignored requests: start re-pulsed in cycle 2 and pattern changed to 4'b0000 in cycle 2 → output identical to test 1; exactly one done pulse.
5. Reset mid-operation: Reset asserted asynchronously in cycle 3 → w, w_valid, done, count=0 and ready=1 immediately; no done pulse; a fresh start afterwards reproduces test 1 timing.
6. repeat=0 → behaves exactly as repeat=1 (single frame, done in cycle 5, count=1).
